core_mul_arbiter: RTL
=====================

CORE_MUL_ARBITER -- requirements
Module: core_mul_arbiter

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst_n input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have per-requester ports, i in {0,1}: rq_valid[i] in 1 (request pending); rq_a[i], rq_b[i], rq_c_hi[i], rq_c_lo[i] in word (operands); rq_long[i], rq_add[i], rq_sig[i] in 1 (mode bits); rq_done[i] out 1 (result pulse).
REQ-003 SHALL have shared result ports: res_hi, res_lo out word (q_hi/q_lo of finished op); res_id out 1 (owner of result).
REQ-004 SHALL have multiplier-side ports: mul_a, mul_b, mul_c_hi, mul_c_lo out word; mul_long, mul_add, mul_sig, mul_start out 1; mul_q_hi, mul_q_lo in word; mul_ready in 1.
REQ-005 SHALL have status ports: busy out 1 (state != IDLE); owner out 1 (requester being served).

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-007 IDLE: if any rq_valid and mul_ready=1, SHALL select winner, latch its operands/mode bits into internal registers, set owner, go to ISSUE; else stay.
REQ-008 Arbitration SHALL be round-robin: 1-bit priority pointer; both valid -> pointer's requester wins; single valid -> that requester wins; pointer SHALL update to ~winner at each grant.
REQ-009 ISSUE: mul_start=1 for exactly this one cycle; SHALL go to WAIT unconditionally.
REQ-010 WAIT: mul_start=0; on mul_ready=1, SHALL capture mul_q_hi/mul_q_lo into res_hi/res_lo, res_id<=owner, go to DONE.
REQ-011 DONE: rq_done[owner]=1 for exactly one cycle, rq_done[~owner]=0; SHALL go to IDLE.
REQ-012 mul_a..mul_sig SHALL be driven from latched registers and held stable from ISSUE through the WAIT cycle that captures the result.
REQ-013 Latency with a multiplier asserting ready 4 cycles after start: rq_valid seen at cycle T -> mul_start at T+1 -> capture at T+5 -> rq_done at T+6; next grant no earlier than T+7.
REQ-014 rq_done SHALL never be asserted outside DONE; at most one rq_done bit high per cycle.
REQ-015 Requester SHALL hold rq_valid until its rq_done; arbiter SHALL ignore rq_valid/operand changes after latching; deassertion mid-operation SHALL NOT abort it, rq_done still pulses.
REQ-016 res_hi/res_lo/res_id SHALL hold their value until next capture.
REQ-017 mul_ready=0 in IDLE SHALL block grants (no start issued).
REQ-018 Losing requester SHALL remain pending and be granted on the next IDLE grant.

Reset
REQ-019 rst_n low SHALL force state IDLE, pointer 0, owner 0, mul_start 0, rq_done 0, res_hi/res_lo 0, res_id 0, latched operands/mode 0, busy 0.
REQ-020 Reset mid-operation (ISSUE/WAIT/DONE) SHALL drop the operation with no rq_done pulse; first grant after release follows REQ-007 with pointer 0.

Structure
REQ-021 word/dword types SHALL come from the shared core microarchitecture package; the FSM state enum and requester count constant (2) SHALL be added there.
REQ-022 Block SHALL contain one sub-module, core_mul_rr_pick (2-way round-robin picker: valid[1:0], pointer -> grant, winner).
REQ-023 Block SHALL be purely sequencing; no arithmetic performed internally.

Verification (bench multiplier model: ready low for 4 cycles after start, q = a*b+c)
REQ-024 Reset then rq_valid[0]=1, a=3, b=5, add=0 -> mul_start at T+1, rq_done[0] at T+6, res_lo=15, res_hi=0, res_id=0.
REQ-025 Both valid same cycle, pointer 0 -> req0 served first, req1 granted next IDLE; rq_done order 0 then 1; third pair of simultaneous requests -> 0 first again.
REQ-026 rq_valid[1], sig=1, a=-2, b=3, add=1, long=0, c_lo=-1 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFF9 (-7).
REQ-027 rq_valid[0] deasserted and rq_a changed the cycle after grant -> mul_a unchanged through capture; rq_done[0] still pulses with original result.
REQ-028 rst_n low during WAIT -> no rq_done, busy=0, all outputs 0 next cycle; new request after release served normally.
REQ-029 mul_ready held low in IDLE with rq_valid[0]=1 -> no mul_start; release ready -> mul_start one cycle after ready seen.

Source files
------------

// File: rtl/core_mul_arbiter_pkg.sv
// Shared core microarchitecture types plus the multiplier arbiter's state
// encoding, requester count and latched-operation record.
package core_mul_arbiter_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;
  localparam int NUM_REQ = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [DWORD_W-1:0] dword_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Everything the multiplier needs for one operation, captured at grant time
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c_hi;
    word_t c_lo;
    logic  long_op;
    logic  add;
    logic  sig;
  } mul_op_t;

  // Turns a requester index into its one-hot done/grant position
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/core_mul_rr_pick.sv
// Two-way round-robin picker: the pointer only matters when both requesters
// are valid; a lone valid requester always wins.
module core_mul_rr_pick
  import core_mul_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               winner_o
);

  // Pick the winner index and its one-hot grant from the valid mask
  always_comb begin
    winner_o = 1'b0;
    grant_o  = '0;
    if (valid_i == 2'b11) begin
      winner_o = ptr_i;
    end else begin
      winner_o = valid_i[1];
    end
    if (valid_i != 2'b00) begin
      grant_o = req_onehot(winner_o);
    end
  end

endmodule

// File: rtl/core_mul_arbiter.sv
// Sequencer that shares one multi-cycle multiplier between two requesters.
// It latches the winner's operands, pulses start, waits for ready, captures
// the result and pulses the owner's done bit. No arithmetic is done here.
module core_mul_arbiter
  import core_mul_arbiter_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              rq_valid_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  rq_a_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  rq_b_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  rq_c_hi_i,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  rq_c_lo_i,
  input  logic [NUM_REQ-1:0]              rq_long_i,
  input  logic [NUM_REQ-1:0]              rq_add_i,
  input  logic [NUM_REQ-1:0]              rq_sig_i,
  output logic [NUM_REQ-1:0]              rq_done_o,
  output logic [WORD_W-1:0]               res_hi_o,
  output logic [WORD_W-1:0]               res_lo_o,
  output logic                            res_id_o,
  output logic [WORD_W-1:0]               mul_a_o,
  output logic [WORD_W-1:0]               mul_b_o,
  output logic [WORD_W-1:0]               mul_c_hi_o,
  output logic [WORD_W-1:0]               mul_c_lo_o,
  output logic                            mul_long_o,
  output logic                            mul_add_o,
  output logic                            mul_sig_o,
  output logic                            mul_start_o,
  input  logic [WORD_W-1:0]               mul_q_hi_i,
  input  logic [WORD_W-1:0]               mul_q_lo_i,
  input  logic                            mul_ready_i,
  output logic                            busy_o,
  output logic                            owner_o
);

  arb_state_e          state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                owner_q, owner_d;
  mul_op_t             op_q, op_d;
  word_t               res_hi_q, res_hi_d;
  word_t               res_lo_q, res_lo_d;
  logic                res_id_q, res_id_d;

  logic [NUM_REQ-1:0]  grant;
  logic                winner;
  mul_op_t             win_op;

  core_mul_rr_pick u_pick (
    .valid_i  (rq_valid_i),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  // Gather the winning requester's operands and mode bits into one record
  always_comb begin
    win_op.a       = rq_a_i[winner];
    win_op.b       = rq_b_i[winner];
    win_op.c_hi    = rq_c_hi_i[winner];
    win_op.c_lo    = rq_c_lo_i[winner];
    win_op.long_op = rq_long_i[winner];
    win_op.add     = rq_add_i[winner];
    win_op.sig     = rq_sig_i[winner];
  end

  // Next-state, register updates and handshake outputs for the four-state sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_id_d    = res_id_q;
    mul_start_o = 1'b0;
    rq_done_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A busy multiplier blocks grants; requests just stay pending
        if ((grant != '0) && mul_ready_i) begin
          op_d    = win_op;
          owner_d = winner;
          ptr_d   = ~winner;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_start_o = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_ready_i) begin
          res_hi_d = mul_q_hi_i;
          res_lo_d = mul_q_lo_i;
          res_id_d = owner_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        rq_done_o = req_onehot(owner_q);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_id_q <= res_id_d;
    end
  end

  assign mul_a_o    = op_q.a;
  assign mul_b_o    = op_q.b;
  assign mul_c_hi_o = op_q.c_hi;
  assign mul_c_lo_o = op_q.c_lo;
  assign mul_long_o = op_q.long_op;
  assign mul_add_o  = op_q.add;
  assign mul_sig_o  = op_q.sig;

  assign res_hi_o = res_hi_q;
  assign res_lo_o = res_lo_q;
  assign res_id_o = res_id_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign owner_o  = owner_q;

endmodule
